modexp_datapath: RTL and testbench

//  Datapath/responder for the modexp controller FSM: computes base^exp mod m by repeated multiply/modulo.

---
 rtl/modexp_pkg.sv | 15 +
 rtl/modexp_operand_buffer.sv | 46 ++++
 rtl/modexp_datapath.sv | 129 ++++++++++++
 tb/tb_modexp_datapath.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared widths and controller state encoding for the modular-exponentiation datapath.
package modexp_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int EXP_WIDTH_DEF = 32;

    // Controller states, WAITING issues initialize and DONE issues done.
    typedef enum logic [1:0] {
        ST_WAITING,
        ST_MULTIPLY,
        ST_MODULO,
        ST_DONE
    } ctrl_state_t;

endpackage

// File: rtl/modexp_operand_buffer.sv
// One-entry valid/ready holding register for the (base, exp, mod) operand triple.
module modexp_operand_buffer
    import modexp_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_base,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic [WIDTH-1:0]     in_mod,
    input  logic                 take,
    output logic                 full,
    output logic [WIDTH-1:0]     base,
    output logic [EXP_WIDTH-1:0] exp,
    output logic [WIDTH-1:0]     mod
);

    logic capture;

    assign in_ready = !full;
    assign capture  = in_valid && !full;

    // take and capture are exclusive: take needs a full slot, capture an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (take) begin
            full <= 1'b0;
        end else if (capture) begin
            full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            base <= in_base;
            exp  <= in_exp;
            mod  <= in_mod;
        end
    end

endmodule

// File: rtl/modexp_datapath.sv
// Multiply/modulo datapath that computes base^exp mod m under the strobes of the modexp controller.
module modexp_datapath
    import modexp_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_WIDTH = EXP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [WIDTH-1:0]     op_base,
    input  logic [EXP_WIDTH-1:0] op_exp,
    input  logic [WIDTH-1:0]     op_mod,
    input  logic                 initialize,
    input  logic                 en_multiply,
    input  logic                 en_modulo,
    input  logic                 done,
    output logic                 input_data_ready,
    output logic                 is_multiplication_done,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_value,
    output logic                 res_error
);

    logic                 pend_full;
    logic [WIDTH-1:0]     pend_base;
    logic [EXP_WIDTH-1:0] pend_exp;
    logic [WIDTH-1:0]     pend_mod;
    logic                 start;

    logic                 job_active;
    logic                 err;
    logic [EXP_WIDTH-1:0] count;
    logic [WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     base_r;
    logic [WIDTH-1:0]     mod_r;
    logic [2*WIDTH-1:0]   mod_ext;
    logic [WIDTH-1:0]     rem;

    modexp_operand_buffer #(
        .WIDTH     (WIDTH),
        .EXP_WIDTH (EXP_WIDTH)
    ) u_operand_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (op_valid),
        .in_ready (op_ready),
        .in_base  (op_base),
        .in_exp   (op_exp),
        .in_mod   (op_mod),
        .take     (start),
        .full     (pend_full),
        .base     (pend_base),
        .exp      (pend_exp),
        .mod      (pend_mod)
    );

    // A job may only start while the result slot is empty, so done never overwrites.
    assign input_data_ready       = pend_full && !res_valid;
    assign start                  = initialize && input_data_ready;
    assign is_multiplication_done = (count == '0);

    assign mod_ext = {{WIDTH{1'b0}}, mod_r};
    assign rem     = (mod_r == '0) ? '0 : WIDTH'(prod % mod_ext);

    always_ff @(posedge clk) begin
        if (start) begin
            base_r <= pend_base;
            mod_r  <= pend_mod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_active <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            acc        <= '0;
            prod       <= '0;
        end else begin
            if (initialize) begin
                if (start) begin
                    job_active <= 1'b1;
                    if (pend_mod == '0) begin
                        // Modulus zero: report an error without iterating.
                        count <= '0;
                        err   <= 1'b1;
                        acc   <= '0;
                    end else begin
                        count <= pend_exp;
                        err   <= 1'b0;
                        acc   <= (pend_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
                    end
                end else begin
                    job_active <= 1'b0;
                    count      <= '0;
                end
            end
            if (en_multiply) begin
                prod  <= {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, base_r};
                count <= count - EXP_WIDTH'(1);
            end
            if (en_modulo) begin
                acc <= rem;
            end
            if (done && job_active) begin
                job_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_value <= '0;
            res_error <= 1'b0;
        end else if (done && job_active) begin
            res_valid <= 1'b1;
            res_value <= acc;
            res_error <= err;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_modexp_datapath.sv
// Scoreboard bench: a behavioural controller drives the strobes, a square-and-multiply model predicts results.
module tb_modexp_datapath;
    import modexp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] op_base = '0;
    logic [31:0] op_exp = '0;
    logic [31:0] op_mod = '0;
    logic        initialize, en_multiply, en_modulo, done;
    logic        input_data_ready, is_multiplication_done;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_value;
    logic        res_error;

    always #5 clk = ~clk;

    modexp_datapath #(.WIDTH(32), .EXP_WIDTH(32)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .op_valid               (op_valid),
        .op_ready               (op_ready),
        .op_base                (op_base),
        .op_exp                 (op_exp),
        .op_mod                 (op_mod),
        .initialize             (initialize),
        .en_multiply            (en_multiply),
        .en_modulo              (en_modulo),
        .done                   (done),
        .input_data_ready       (input_data_ready),
        .is_multiplication_done (is_multiplication_done),
        .res_valid              (res_valid),
        .res_ready              (res_ready),
        .res_value              (res_value),
        .res_error              (res_error)
    );

    // Behavioural controller: initialize, multiply/modulo pairs until the count runs out, done, repeat.
    ctrl_state_t cst;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cst <= ST_WAITING;
        else begin
            case (cst)
                ST_WAITING:  cst <= ST_MULTIPLY;
                ST_MULTIPLY: cst <= is_multiplication_done ? ST_DONE : ST_MODULO;
                ST_MODULO:   cst <= ST_MULTIPLY;
                default:     cst <= ST_WAITING;
            endcase
        end
    end

    always_comb begin
        initialize  = (cst == ST_WAITING);
        en_multiply = (cst == ST_MULTIPLY) && !is_multiplication_done;
        en_modulo   = (cst == ST_MODULO);
        done        = (cst == ST_DONE);
    end

    typedef struct {
        logic [31:0] value;
        logic        err;
        int unsigned exp;
        logic [31:0] mod;
    } job_t;

    job_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rand_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_modexp(input logic [31:0] b, input int unsigned e, input logic [31:0] m);
        logic [63:0] r, bb, mm;
        int unsigned k;
        if (m == 0) return 32'd0;
        mm = {32'd0, m};
        r  = 64'd1 % mm;
        bb = {32'd0, b} % mm;
        k  = e;
        while (k != 0) begin
            if (k[0]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
            k  = k >> 1;
        end
        return r[31:0];
    endfunction

    // Monitor: pops the scoreboard on each result handshake and checks job timing.
    bit started = 0;
    bit done_seen = 0;
    int start_cyc = 0;
    int lat_req = 0;
    always @(negedge clk) begin
        job_t e;
        if (!rst_n) begin
            started   = 0;
            done_seen = 0;
        end else begin
            if (done_seen) begin
                check("res_valid_after_done", res_valid, 1);
                done_seen = 0;
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h required=none", res_value);
                end else begin
                    e = sb.pop_front();
                    check("res_value", res_value, e.value);
                    check("res_error", res_error, e.err);
                end
            end
            if (initialize && input_data_ready) begin
                started   = 1;
                start_cyc = cyc;
                if (sb.size() == 0) lat_req = -1;
                else lat_req = (sb[0].mod == 0) ? 2 : 2 * int'(sb[0].exp) + 2;
            end
            if (done && started) begin
                check("init_to_done_latency", cyc - start_cyc, lat_req);
                started   = 0;
                done_seen = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] b, input int unsigned e, input logic [31:0] m);
        bit   took = 0;
        job_t j;
        op_base  = b;
        op_exp   = e;
        op_mod   = m;
        op_valid = 1'b1;
        for (int i = 0; i < 2000 && !took; i++) begin
            took = op_ready;
            if (took) begin
                j.value = ref_modexp(b, e, m);
                j.err   = (m == 0);
                j.exp   = e;
                j.mod   = m;
                sb.push_back(j);
            end
            tick();
        end
        op_valid = 1'b0;
        if (!took) check("op_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && sb.size() != 0; i++) tick();
        check("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_op_ready", op_ready, 1);
        check("rst_input_data_ready", input_data_ready, 0);
        check("rst_mult_done", is_multiplication_done, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_value", res_value, 0);
        check("rst_res_error", res_error, 0);
    endtask

    initial begin
        bit seen;
        #12;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        send(32'd3, 4, 32'd7);
        send(32'd2, 10, 32'd1000);
        send(32'hFFFF_FFFF, 2, 32'hFFFF_FFFB);
        send(32'd9, 0, 32'd5);
        send(32'd6, 3, 32'd1);
        send(32'd4, 7, 32'd0);
        drain();

        // Held result blocks the queued operand from starting.
        res_ready = 1'b0;
        send(32'd3, 4, 32'd7);
        send(32'd5, 3, 32'd13);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            seen = res_valid;
            tick();
        end
        check("hold_result_appeared", seen, 1);
        repeat (20) tick();
        check("hold_op_ready", op_ready, 0);
        check("hold_res_valid", res_valid, 1);
        check("hold_res_value", res_value, 4);
        check("hold_input_data_ready", input_data_ready, 0);
        check("hold_no_start", is_multiplication_done, 1);
        res_ready = 1'b1;
        drain();

        // Reset in the middle of a long job discards it.
        send(32'd3, 20, 32'd1000003);
        for (int i = 0; i < 100 && input_data_ready; i++) tick();
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_reset_outputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(32'd2, 3, 32'd5);
        drain();

        rand_mode = 1;
        for (int n = 0; n < 25; n++) begin
            logic [31:0] m;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            m = (sel == 0) ? 32'd0 : (sel == 1) ? 32'd1 : $urandom;
            send($urandom, $urandom_range(0, 12), m);
        end
        drain();
        rand_mode = 0;
        res_ready = 1'b1;

        // No operand pending: the controller spins and no result appears.
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (res_valid) seen = 1;
            tick();
        end
        check("idle_no_result", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
